// File: rtl/ddr_pkg.sv
// ---------------------------------------------------------------------------
// ddr_pkg
// Shared DDR command-bus types and default timing constants.
//   cmd_t       : command encoding seen by the command generator.
//   ref_state_t : refresh sequencer FSM states.
//   *_DEF       : default parameter values for the refresh path.
// ---------------------------------------------------------------------------
package ddr_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_PREA = 2'd1,
    CMD_REF  = 2'd2
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_PREA     = 3'd2,
    ST_WAIT_RP  = 3'd3,
    ST_REF      = 3'd4,
    ST_WAIT_RFC = 3'd5
  } ref_state_t;

  localparam int T_RP_DEF     = 6;
  localparam int T_RFC_DEF    = 88;
  localparam int PEND_MAX_DEF = 9;
  localparam int NBANK_DEF    = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/refresh_sequencer_if.sv
// ---------------------------------------------------------------------------
// refresh_sequencer_if
// Bundles the grant input, bank/scheduler status, command-bus handshake and
// status outputs of the refresh sequencer.
//   master : the sequencer (drives ref_hold, cmd_*, ref_done, pending, overflow)
//   slave  : the surrounding controller/scheduler/arbiter side
// ---------------------------------------------------------------------------
interface refresh_sequencer_if #(
  parameter int NBANK = 8
) ();
  logic             ref_do;
  logic [NBANK-1:0] bank_open;
  logic             sched_idle;
  logic             ref_hold;
  logic             cmd_valid;
  logic [1:0]       cmd_type;
  logic             cmd_ready;
  logic             ref_done;
  logic [3:0]       pending;
  logic             overflow;

  modport master (
    input  ref_do, bank_open, sched_idle, cmd_ready,
    output ref_hold, cmd_valid, cmd_type, ref_done, pending, overflow
  );

  modport slave (
    output ref_do, bank_open, sched_idle, cmd_ready,
    input  ref_hold, cmd_valid, cmd_type, ref_done, pending, overflow
  );
endinterface

// File: rtl/wait_timer.sv
// ---------------------------------------------------------------------------
// wait_timer
// Load / decrement down-counter with zero flags. Load has priority over
// decrement; the counter saturates at zero instead of wrapping.
//   clk, rst     : clock, synchronous active-high reset
//   i_load       : load i_load_val
//   i_dec        : decrement by one (ignored at zero)
//   o_zero       : count == 0
//   o_one        : count == 1 (next decrement reaches zero)
// ---------------------------------------------------------------------------
module wait_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero,
  output logic         o_one
);
  logic [W-1:0] r_count;

  // Counter register: load, saturating decrement, or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_zero = (r_count == '0);
  assign o_one  = (r_count == W'(1));
endmodule

// File: rtl/refresh_sequencer.sv
// ---------------------------------------------------------------------------
// refresh_sequencer
// Turns refresh grants into DDR command-bus traffic: quiesce the scheduler,
// PREA if any bank is open, REF, then hold the bus for tRFC. Queued grants
// chain straight into the next REF without another drain/PREA.
//   core_clk, core_rst : clock, synchronous active-high reset
//   bus (master)       : ref_do, bank_open, sched_idle, cmd_ready in;
//                        ref_hold, cmd_valid, cmd_type, ref_done,
//                        pending, overflow out (all registered)
// ---------------------------------------------------------------------------
module refresh_sequencer
  import ddr_pkg::*;
#(
  parameter int T_RP     = T_RP_DEF,
  parameter int T_RFC    = T_RFC_DEF,
  parameter int PEND_MAX = PEND_MAX_DEF,
  parameter int NBANK    = NBANK_DEF
) (
  input  logic                core_clk,
  input  logic                core_rst,
  refresh_sequencer_if.master bus
);
  localparam int TW_RAW = $clog2(max_int(T_RP, T_RFC));
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam logic [3:0] PEND_MAX_L = 4'(PEND_MAX);

  ref_state_t r_state, w_state_next;
  logic [3:0] r_pending, w_pend_next;
  logic       r_overflow, r_ref_hold, r_cmd_valid, r_ref_done;
  cmd_t       r_cmd_type;
  logic       w_inc, w_dec, w_any_open, w_done_next;
  logic       w_tmr_load, w_tmr_dec, w_tmr_zero, w_tmr_one;
  logic [TW-1:0] w_tmr_val;

  wait_timer #(.W(TW)) u_timer (
    .clk        (core_clk),
    .rst        (core_rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero),
    .o_one      (w_tmr_one)
  );

  // A grant at the cap is dropped; REF acceptance is the only decrement.
  assign w_inc       = bus.ref_do && (r_pending != PEND_MAX_L);
  assign w_dec       = (r_state == ST_REF) && bus.cmd_ready;
  assign w_pend_next = r_pending + {3'b000, w_inc} - {3'b000, w_dec};
  assign w_any_open  = |bus.bank_open[NBANK-1:0];

  // Next-state and timer control. Waits exit on the edge where the timer
  // reaches zero so the following command lands exactly T cycles later.
  always_comb begin
    w_state_next = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    w_tmr_dec    = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pending != 4'd0) w_state_next = ST_DRAIN;
        else                   w_state_next = ST_IDLE;
      end
      ST_DRAIN: begin
        if (bus.sched_idle) w_state_next = w_any_open ? ST_PREA : ST_REF;
        else                w_state_next = ST_DRAIN;
      end
      ST_PREA: begin
        if (!bus.cmd_ready) begin
          w_state_next = ST_PREA;
        end else if (T_RP == 1) begin
          w_state_next = ST_REF;
        end else begin
          w_tmr_load   = 1'b1;
          w_tmr_val    = TW'(T_RP - 1);
          w_state_next = ST_WAIT_RP;
        end
      end
      ST_WAIT_RP: begin
        w_tmr_dec = 1'b1;
        if (w_tmr_one || w_tmr_zero) w_state_next = ST_REF;
        else                         w_state_next = ST_WAIT_RP;
      end
      ST_REF: begin
        if (!bus.cmd_ready) begin
          w_state_next = ST_REF;
        end else if ((T_RFC == 1) && (w_pend_next != 4'd0)) begin
          w_state_next = ST_REF;
        end else begin
          w_tmr_load   = 1'b1;
          w_tmr_val    = TW'(T_RFC - 1);
          w_state_next = ST_WAIT_RFC;
          w_done_next  = (T_RFC == 1);
        end
      end
      ST_WAIT_RFC: begin
        // r_ref_done marks the extra cycle that keeps ref_hold up after done.
        if (r_ref_done) begin
          w_state_next = ST_IDLE;
        end else if (w_tmr_one || w_tmr_zero) begin
          if (w_pend_next != 4'd0) begin
            w_state_next = ST_REF;
          end else begin
            w_state_next = ST_WAIT_RFC;
            w_done_next  = 1'b1;
          end
        end else begin
          w_tmr_dec    = 1'b1;
          w_state_next = ST_WAIT_RFC;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge core_clk) begin
    if (core_rst) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Output registers, decoded from the next state so they align with it.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      r_ref_hold  <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= CMD_NOP;
      r_ref_done  <= 1'b0;
      r_pending   <= 4'd0;
      r_overflow  <= 1'b0;
    end else begin
      r_ref_hold  <= (w_state_next != ST_IDLE);
      r_cmd_valid <= (w_state_next == ST_PREA) || (w_state_next == ST_REF);
      case (w_state_next)
        ST_PREA: r_cmd_type <= CMD_PREA;
        ST_REF:  r_cmd_type <= CMD_REF;
        default: r_cmd_type <= CMD_NOP;
      endcase
      r_ref_done  <= w_done_next;
      r_pending   <= w_pend_next;
      r_overflow  <= r_overflow || (bus.ref_do && (r_pending == PEND_MAX_L));
    end
  end

  assign bus.ref_hold  = r_ref_hold;
  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_type  = r_cmd_type;
  assign bus.ref_done  = r_ref_done;
  assign bus.pending   = r_pending;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_refresh_sequencer.sv
// ---------------------------------------------------------------------------
// tb_refresh_sequencer
// Directed bench for refresh_sequencer with default timing (T_RP=6,
// T_RFC=88, PEND_MAX=9). Inputs change 1 time unit after each rising edge;
// outputs are sampled at that same point, i.e. they show the state of the
// cycle that just began.
// ---------------------------------------------------------------------------
module tb_refresh_sequencer;
  localparam int T_RP  = 6;
  localparam int T_RFC = 88;

  logic core_clk = 1'b0;
  logic core_rst;
  int   n_total  = 0;
  int   n_pass   = 0;

  refresh_sequencer_if #(.NBANK(8)) bus ();

  refresh_sequencer #(
    .T_RP     (T_RP),
    .T_RFC    (T_RFC),
    .PEND_MAX (9),
    .NBANK    (8)
  ) dut (
    .core_clk (core_clk),
    .core_rst (core_rst),
    .bus      (bus)
  );

  always #5 core_clk = ~core_clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge core_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    core_rst       = 1'b1;
    bus.ref_do     = 1'b0;
    bus.bank_open  = 8'h00;
    bus.sched_idle = 1'b0;
    bus.cmd_ready  = 1'b0;
    tick(3);
    chk("rst_hold",     32'(bus.ref_hold),  32'd0);
    chk("rst_valid",    32'(bus.cmd_valid), 32'd0);
    chk("rst_type",     32'(bus.cmd_type),  32'd0);
    chk("rst_done",     32'(bus.ref_done),  32'd0);
    chk("rst_pending",  32'(bus.pending),   32'd0);
    chk("rst_overflow", 32'(bus.overflow),  32'd0);
    core_rst = 1'b0;
    tick(2);
    chk("idle_hold", 32'(bus.ref_hold), 32'd0);

    // 1: closed banks, grant at n -> REF at n+3, done at r+88
    bus.sched_idle = 1'b1;
    bus.cmd_ready  = 1'b1;
    bus.ref_do     = 1'b1;
    tick(1);
    bus.ref_do = 1'b0;
    chk("t1_pend1",  32'(bus.pending),   32'd1);
    chk("t1_hold0",  32'(bus.ref_hold),  32'd0);
    tick(1);
    chk("t1_hold1",  32'(bus.ref_hold),  32'd1);
    chk("t1_novld",  32'(bus.cmd_valid), 32'd0);
    tick(1);
    chk("t1_ref_v",  32'(bus.cmd_valid), 32'd1);
    chk("t1_ref_t",  32'(bus.cmd_type),  32'd2);
    tick(1);
    chk("t1_pend0",  32'(bus.pending),   32'd0);
    chk("t1_vld0",   32'(bus.cmd_valid), 32'd0);
    tick(T_RFC - 2);
    chk("t1_early",  32'(bus.ref_done),  32'd0);
    tick(1);
    chk("t1_done",   32'(bus.ref_done),  32'd1);
    chk("t1_hold_d", 32'(bus.ref_hold),  32'd1);
    tick(1);
    chk("t1_done0",  32'(bus.ref_done),  32'd0);
    chk("t1_hold_f", 32'(bus.ref_hold),  32'd0);

    // 2: bank 2 open -> PREA at n+3, REF at p+6, done at r+88
    bus.bank_open = 8'h04;
    bus.ref_do    = 1'b1;
    tick(1);
    bus.ref_do = 1'b0;
    tick(2);
    chk("t2_prea_v", 32'(bus.cmd_valid), 32'd1);
    chk("t2_prea_t", 32'(bus.cmd_type),  32'd1);
    tick(1);
    bus.bank_open = 8'h00;
    chk("t2_rp_v1",  32'(bus.cmd_valid), 32'd0);
    tick(T_RP - 2);
    chk("t2_rp_v5",  32'(bus.cmd_valid), 32'd0);
    tick(1);
    chk("t2_ref_v",  32'(bus.cmd_valid), 32'd1);
    chk("t2_ref_t",  32'(bus.cmd_type),  32'd2);
    tick(T_RFC);
    chk("t2_done",   32'(bus.ref_done),  32'd1);
    tick(1);
    chk("t2_hold_f", 32'(bus.ref_hold),  32'd0);
    chk("t2_pend0",  32'(bus.pending),   32'd0);

    // 3: scheduler busy 20 cycles in DRAIN, REF one cycle after sched_idle
    bus.sched_idle = 1'b0;
    bus.ref_do     = 1'b1;
    tick(1);
    bus.ref_do = 1'b0;
    tick(1);
    for (int i = 0; i < 20; i++) begin
      chk("t3_hold", 32'(bus.ref_hold),  32'd1);
      chk("t3_vld",  32'(bus.cmd_valid), 32'd0);
      if (i == 19) bus.sched_idle = 1'b1;
      tick(1);
    end
    chk("t3_ref_v",  32'(bus.cmd_valid), 32'd1);
    chk("t3_ref_t",  32'(bus.cmd_type),  32'd2);
    tick(T_RFC);
    chk("t3_done",   32'(bus.ref_done),  32'd1);
    tick(1);
    chk("t3_hold_f", 32'(bus.ref_hold),  32'd0);

    // 4: cmd_ready low for 5 REF cycles, single decrement on acceptance
    bus.cmd_ready = 1'b0;
    bus.ref_do    = 1'b1;
    tick(1);
    bus.ref_do = 1'b0;
    tick(2);
    for (int i = 0; i < 5; i++) begin
      chk("t4_bp_v", 32'(bus.cmd_valid), 32'd1);
      chk("t4_bp_t", 32'(bus.cmd_type),  32'd2);
      chk("t4_bp_p", 32'(bus.pending),   32'd1);
      tick(1);
    end
    chk("t4_acc_v",  32'(bus.cmd_valid), 32'd1);
    chk("t4_acc_t",  32'(bus.cmd_type),  32'd2);
    bus.cmd_ready = 1'b1;
    tick(1);
    chk("t4_pend0",  32'(bus.pending),   32'd0);
    chk("t4_vld0",   32'(bus.cmd_valid), 32'd0);
    tick(T_RFC - 1);
    chk("t4_done",   32'(bus.ref_done),  32'd1);
    tick(1);
    chk("t4_hold_f", 32'(bus.ref_hold),  32'd0);

    // 5: three grants, second in the REF handshake cycle; banks reopen
    // after the first REF so any PREA would show as cmd_type 1
    bus.ref_do = 1'b1;
    tick(1);
    bus.ref_do = 1'b0;
    tick(2);
    chk("t5_r1_v",   32'(bus.cmd_valid), 32'd1);
    chk("t5_r1_t",   32'(bus.cmd_type),  32'd2);
    bus.bank_open = 8'hFF;
    bus.ref_do    = 1'b1;
    tick(1);
    bus.ref_do = 1'b0;
    chk("t5_same",   32'(bus.pending),   32'd1);
    tick(6);
    bus.ref_do = 1'b1;
    tick(1);
    bus.ref_do = 1'b0;
    chk("t5_pend2",  32'(bus.pending),   32'd2);
    tick(T_RFC - 9);
    chk("t5_gap1",   32'(bus.cmd_valid), 32'd0);
    tick(1);
    chk("t5_r2_v",   32'(bus.cmd_valid), 32'd1);
    chk("t5_r2_t",   32'(bus.cmd_type),  32'd2);
    chk("t5_r2_d",   32'(bus.ref_done),  32'd0);
    tick(1);
    chk("t5_pend1",  32'(bus.pending),   32'd1);
    tick(T_RFC - 2);
    chk("t5_gap2",   32'(bus.cmd_valid), 32'd0);
    tick(1);
    chk("t5_r3_v",   32'(bus.cmd_valid), 32'd1);
    chk("t5_r3_t",   32'(bus.cmd_type),  32'd2);
    chk("t5_r3_h",   32'(bus.ref_hold),  32'd1);
    tick(1);
    chk("t5_pend0",  32'(bus.pending),   32'd0);
    tick(T_RFC - 2);
    chk("t5_early",  32'(bus.ref_done),  32'd0);
    tick(1);
    chk("t5_done",   32'(bus.ref_done),  32'd1);
    tick(1);
    chk("t5_done0",  32'(bus.ref_done),  32'd0);
    chk("t5_hold_f", 32'(bus.ref_hold),  32'd0);
    bus.bank_open = 8'h00;

    // 6: ten grants saturate at 9 and set overflow; reset mid-WAIT_RFC
    bus.sched_idle = 1'b0;
    bus.ref_do     = 1'b1;
    tick(9);
    chk("t6_pend9",  32'(bus.pending),   32'd9);
    chk("t6_ovf0",   32'(bus.overflow),  32'd0);
    tick(1);
    bus.ref_do = 1'b0;
    chk("t6_sat",    32'(bus.pending),   32'd9);
    chk("t6_ovf1",   32'(bus.overflow),  32'd1);
    bus.sched_idle = 1'b1;
    tick(1);
    chk("t6_ref_v",  32'(bus.cmd_valid), 32'd1);
    tick(1);
    chk("t6_pend8",  32'(bus.pending),   32'd8);
    chk("t6_sticky", 32'(bus.overflow),  32'd1);
    tick(8);
    chk("t6_hold",   32'(bus.ref_hold),  32'd1);
    core_rst = 1'b1;
    tick(1);
    chk("t6_r_hold", 32'(bus.ref_hold),  32'd0);
    chk("t6_r_vld",  32'(bus.cmd_valid), 32'd0);
    chk("t6_r_type", 32'(bus.cmd_type),  32'd0);
    chk("t6_r_done", 32'(bus.ref_done),  32'd0);
    chk("t6_r_pend", 32'(bus.pending),   32'd0);
    chk("t6_r_ovf",  32'(bus.overflow),  32'd0);
    core_rst = 1'b0;
    tick(3);
    chk("t6_post_h", 32'(bus.ref_hold),  32'd0);
    chk("t6_post_v", 32'(bus.cmd_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
